// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory: bus widths, control levels,
// loader FSM encoding and the big-endian byte-lane helper.
package inst_mem_pkg;

    // Bus widths seen by the PC stage.
    localparam int unsigned InstBus     = 32;
    localparam int unsigned InstAddrBus = 32;

    // Word returned for misaligned or unserviced fetches.
    localparam logic [InstBus-1:0] NopInst = 32'h0000_0000;

    // Control levels.
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b1;

    // Loader / availability state.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StReady = 2'd2
    } state_e;

    // Insert a byte into the word at big-endian lane 'lane' (lane 0 = bits 31:24).
    function automatic logic [InstBus-1:0] place_byte(input logic [InstBus-1:0] word,
                                                      input logic [7:0]         b,
                                                      input logic [1:0]         lane);
        logic [InstBus-1:0] w;
        w = word;
        unique case (lane)
            2'd0: w[31:24] = b;
            2'd1: w[23:16] = b;
            2'd2: w[15:8]  = b;
            2'd3: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_mem_ram.sv
// DEPTH x 32 storage with one synchronous write port and one synchronous read
// port. Contents are deliberately not reset so an image survives rst.
module inst_mem_ram
    import inst_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [InstBus-1:0]    wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [InstBus-1:0]    rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [InstBus-1:0] mem [DEPTH];

    // Write port: commit an assembled word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with a byte-serial image loader. Fetches are serviced
// only in StReady with one cycle of latency; the loader assembles big-endian
// words and writes each word in the cycle its last byte is accepted.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [InstAddrBus-1:0] addr,
    output logic [InstBus-1:0]     inst,
    output logic                   inst_valid,
    output logic                   addr_err,
    output logic                   busy,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [7:0]             ld_byte,
    input  logic                   ld_last,
    output logic                   ld_ready,
    output logic                   ld_done
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [1:0]            cnt_q;
    logic [InstBus-1:0]    buf_q;
    logic                  done_q;
    logic                  valid_q;
    logic                  err_q;

    logic                  rst_active;
    logic                  accept;
    logic                  word_full;
    logic                  ram_we;
    logic [InstBus-1:0]    merged;
    logic                  fetch;
    logic                  misaligned;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [InstBus-1:0]    ram_rdata;

    // Upper address bits alias onto the array and are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[InstAddrBus-1:ADDR_WIDTH+2];

    // Loader byte acceptance, word assembly and fetch decode.
    always_comb begin
        rst_active = (rst == RstEnable);
        // ld_start beats a coincident byte; rst beats everything.
        accept     = !rst_active && (state_q == StLoad) && ld_valid && !ld_start;
        word_full  = (cnt_q == 2'd3);
        merged     = place_byte(buf_q, ld_byte, cnt_q);
        // Low lanes of buf_q are still zero, so a short final word is zero-padded.
        ram_we     = accept && (word_full || ld_last);
        fetch      = !rst_active && (state_q == StReady) && (ce == ChipEnable);
        misaligned = (addr[1:0] != 2'b00);
        ram_re     = fetch && !misaligned;
        raddr      = addr[ADDR_WIDTH+1:2];
    end

    inst_mem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ptr_q),
        .wdata (merged),
        .re    (ram_re),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // Loader FSM plus registered fetch-response flags.
    always_ff @(posedge clk) begin
        if (rst_active) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= 2'd0;
            buf_q   <= NopInst;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= fetch;
            err_q   <= fetch && misaligned;

            if (ld_start) begin
                // Same restart from any state; a fetch this cycle was already decoded above.
                state_q <= StLoad;
                ptr_q   <= '0;
                cnt_q   <= 2'd0;
                buf_q   <= NopInst;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StIdle;
                    end
                    StLoad: begin
                        if (accept) begin
                            if (ld_last) begin
                                state_q <= StReady;
                                ptr_q   <= ptr_q + ADDR_WIDTH'(1);
                                cnt_q   <= 2'd0;
                                buf_q   <= NopInst;
                                done_q  <= 1'b1;
                            end else if (word_full) begin
                                // Pointer wraps naturally at DEPTH.
                                ptr_q <= ptr_q + ADDR_WIDTH'(1);
                                cnt_q <= 2'd0;
                                buf_q <= NopInst;
                            end else begin
                                cnt_q <= cnt_q + 2'd1;
                                buf_q <= merged;
                            end
                        end
                    end
                    StReady: begin
                        state_q <= StReady;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Outputs: data is gated so only aligned, serviced fetches expose RAM contents.
    always_comb begin
        inst       = (valid_q && !err_q) ? ram_rdata : NopInst;
        inst_valid = valid_q;
        addr_err   = err_q;
        busy       = (state_q != StReady);
        ld_ready   = (state_q == StLoad);
        ld_done    = done_q;
    end

    // Writes only ever come from the loader.
    a_we_in_load : assert property (@(posedge clk) disable iff (rst) ram_we |-> state_q == StLoad);

    // Load completion is reported only once the memory is available.
    a_done_ready : assert property (@(posedge clk) disable iff (rst) ld_done |-> state_q == StReady);

    // Errors are only flagged on valid responses.
    a_err_valid : assert property (@(posedge clk) addr_err |-> inst_valid);

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench: drives a default-size and an ADDR_WIDTH=2 instance with
// identical stimulus and compares both against an image-level memory model.
module tb_inst_mem;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst, ce, ld_start, ld_valid, ld_last;
    logic [31:0] addr;
    logic [7:0]  ld_byte;

    logic [31:0] inst_b, inst_s;
    logic        inst_valid_b, inst_valid_s, addr_err_b, addr_err_s, busy_b, busy_s;
    logic        ld_ready_b, ld_ready_s, ld_done_b, ld_done_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference image: words indexed modulo each instance's depth.
    logic [31:0] mref_b [1024];
    logic [31:0] mref_s [4];
    int          max_words_b = 0;

    always #5 clk = ~clk;

    inst_mem #(.ADDR_WIDTH(10)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
        .inst_valid(inst_valid_b), .addr_err(addr_err_b), .busy(busy_b),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready_b), .ld_done(ld_done_b)
    );

    inst_mem #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_s),
        .inst_valid(inst_valid_s), .addr_err(addr_err_s), .busy(busy_s),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready_s), .ld_done(ld_done_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_b(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 32'h0;
        return mref_b[a[11:2]];
    endfunction

    function automatic logic [31:0] exp_s(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 32'h0;
        return mref_s[a[3:2]];
    endfunction

    // Image semantics: byte i lands in word i/4, lane i%4 (big-endian); a final
    // partial word is zero-padded when terminated by ld_last, dropped otherwise.
    task automatic model_commit(input bq_t q, input bit last);
        int n;
        int nw;
        logic [31:0] w;
        n  = q.size();
        nw = last ? (n + 3) / 4 : n / 4;
        for (int k = 0; k < nw; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n) w[31-8*j -: 8] = q[4*k+j];
            end
            mref_b[k % 1024] = w;
            mref_s[k % 4]    = w;
        end
        if (nw > max_words_b) max_words_b = (nw > 1024) ? 1024 : nw;
    endtask

    // Start pulse followed by the bytes of q; checks handshake along the way.
    task automatic load_image(input bq_t q, input bit with_last, input string tag);
        ld_start = 1'b1;
        ld_valid = 1'b0;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            ld_valid = 1'b1;
            ld_byte  = q[i];
            ld_last  = with_last && (i == q.size() - 1);
            n_checks++;
            if ({ld_ready_b, ld_ready_s, busy_b, busy_s} !== 4'b1111) begin
                n_fail++;
                $display("FAIL %s ld_ready/busy byte %0d: got %b want 1111", tag, i,
                         {ld_ready_b, ld_ready_s, busy_b, busy_s});
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (with_last) begin
            n_checks++;
            if ({ld_done_b, ld_done_s, busy_b, busy_s} !== 4'b1100) begin
                n_fail++;
                $display("FAIL %s ld_done pulse: got %b want 1100", tag,
                         {ld_done_b, ld_done_s, busy_b, busy_s});
            end
            tick();
            n_checks++;
            if ({ld_done_b, ld_done_s} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s ld_done width: got %b want 00", tag, {ld_done_b, ld_done_s});
            end
        end
        model_commit(q, with_last);
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; addr = 32'h0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h0;
        tick();
        tick();
        n_checks++;
        if ({inst_b, inst_valid_b, addr_err_b, ld_ready_b, ld_done_b, busy_b} !==
            {32'h0, 5'b00001}) begin
            n_fail++;
            $display("FAIL reset_b: got %h %b%b%b%b%b", inst_b, inst_valid_b, addr_err_b,
                     ld_ready_b, ld_done_b, busy_b);
        end
        n_checks++;
        if ({inst_s, inst_valid_s, addr_err_s, ld_ready_s, ld_done_s, busy_s} !==
            {32'h0, 5'b00001}) begin
            n_fail++;
            $display("FAIL reset_s: got %h %b%b%b%b%b", inst_s, inst_valid_s, addr_err_s,
                     ld_ready_s, ld_done_s, busy_s);
        end
        rst = 1'b0;
        ce  = 1'b1;
        tick();
        ce = 1'b0;
        n_checks++;
        if ({inst_valid_b, inst_valid_s, busy_b, busy_s} !== 4'b0011) begin
            n_fail++;
            $display("FAIL idle_fetch: got %b want 0011",
                     {inst_valid_b, inst_valid_s, busy_b, busy_s});
        end
    endtask

    task automatic test_basic_load();
        bq_t q;
        for (int i = 0; i < 8; i++) q.push_back(8'(i));
        load_image(q, 1'b1, "basic");
        ce = 1'b1;
        addr = 32'h0;
        tick();
        addr = 32'h4;
        n_checks++;
        if ({inst_b, inst_valid_b, addr_err_b} !== {32'h00010203, 2'b10}) begin
            n_fail++;
            $display("FAIL basic_w0: got %h v%b e%b want 00010203 v1 e0", inst_b, inst_valid_b,
                     addr_err_b);
        end
        tick();
        ce = 1'b0;
        n_checks++;
        if ({inst_b, inst_valid_b, addr_err_b, inst_s, inst_valid_s} !==
            {32'h04050607, 2'b10, 32'h04050607, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_w1: got %h/%h v%b/%b want 04050607", inst_b, inst_s,
                     inst_valid_b, inst_valid_s);
        end
        tick();
        n_checks++;
        if ({inst_b, inst_valid_b, inst_s, inst_valid_s} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL ce_off: got %h v%b / %h v%b want 0 v0", inst_b, inst_valid_b,
                     inst_s, inst_valid_s);
        end
    endtask

    task automatic test_partial();
        bq_t q;
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        load_image(q, 1'b1, "partial");
        ce = 1'b1;
        addr = 32'h4;
        tick();
        addr = 32'h0;
        n_checks++;
        if ({inst_b, inst_s, inst_valid_b} !== {32'hEEFF0000, 32'hEEFF0000, 1'b1}) begin
            n_fail++;
            $display("FAIL partial_pad: got %h/%h want eeff0000", inst_b, inst_s);
        end
        tick();
        ce = 1'b0;
        n_checks++;
        if ({inst_b, inst_s} !== {exp_b(32'h0), exp_s(32'h0)}) begin
            n_fail++;
            $display("FAIL partial_w0: got %h/%h want %h", inst_b, inst_s, exp_b(32'h0));
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] a;
        for (int i = 1; i < 4; i++) begin
            a = 32'h0 | i;
            if (i == 3) a = 32'h0000_0007;
            ce = 1'b1;
            addr = a;
            tick();
            n_checks++;
            if ({inst_b, inst_valid_b, addr_err_b, inst_s, inst_valid_s, addr_err_s} !==
                {32'h0, 2'b11, 32'h0, 2'b11}) begin
                n_fail++;
                $display("FAIL misaligned %h: got %h v%b e%b / %h v%b e%b", a, inst_b,
                         inst_valid_b, addr_err_b, inst_s, inst_valid_s, addr_err_s);
            end
        end
        ce = 1'b0;
        tick();
        n_checks++;
        if ({addr_err_b, addr_err_s, inst_valid_b} !== 3'b000) begin
            n_fail++;
            $display("FAIL err_clear: got %b want 000", {addr_err_b, addr_err_s, inst_valid_b});
        end
    endtask

    task automatic test_load_abort();
        bq_t q;
        bq_t w0;
        q  = '{8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h61, 8'h62};
        w0 = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ce = 1'b1;
        addr = 32'h4;
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1;
            ld_byte  = q[i];
            tick();
            n_checks++;
            if ({inst_valid_b, inst_valid_s, busy_b, busy_s, inst_b} !== {4'b0011, 32'h0}) begin
                n_fail++;
                $display("FAIL fetch_in_load %0d: got v%b/%b busy%b/%b inst %h", i,
                         inst_valid_b, inst_valid_s, busy_b, busy_s, inst_b);
            end
        end
        rst = 1'b1; ld_start = 1'b1; ld_byte = 8'h63;
        tick();
        rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
        model_commit(w0, 1'b0);
        n_checks++;
        if ({busy_b, busy_s, ld_ready_b, ld_ready_s, inst_valid_b, ld_done_b} !== 6'b110000) begin
            n_fail++;
            $display("FAIL rst_in_load: got %b want 110000",
                     {busy_b, busy_s, ld_ready_b, ld_ready_s, inst_valid_b, ld_done_b});
        end
        tick();
        ce = 1'b0;
        n_checks++;
        if ({busy_b, ld_ready_b, inst_valid_b, inst_valid_s} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_after_rst: got %b want 1000",
                     {busy_b, ld_ready_b, inst_valid_b, inst_valid_s});
        end
        load_image(w0, 1'b1, "reload");
        ce = 1'b1;
        addr = 32'h4;
        tick();
        addr = 32'h0;
        n_checks++;
        if ({inst_b, inst_s} !== {32'hEEFF0000, 32'hEEFF0000}) begin
            n_fail++;
            $display("FAIL word1_kept: got %h/%h want eeff0000", inst_b, inst_s);
        end
        tick();
        ce = 1'b0;
        n_checks++;
        if ({inst_b, inst_s} !== {32'h5A5B5C5D, 32'h5A5B5C5D}) begin
            n_fail++;
            $display("FAIL word0_intact: got %h/%h want 5a5b5c5d", inst_b, inst_s);
        end
    endtask

    task automatic test_wrap();
        bq_t q;
        for (int i = 0; i < 20; i++) q.push_back(8'(i));
        load_image(q, 1'b1, "wrap");
        ce = 1'b1;
        addr = 32'h0;
        tick();
        addr = 32'h10;
        n_checks++;
        if ({inst_s, inst_b} !== {32'h10111213, 32'h00010203}) begin
            n_fail++;
            $display("FAIL wrap_w0: got s %h b %h want 10111213 00010203", inst_s, inst_b);
        end
        tick();
        addr = 32'hC;
        n_checks++;
        if ({inst_s, inst_b} !== {32'h10111213, 32'h10111213}) begin
            n_fail++;
            $display("FAIL alias_0x10: got s %h b %h want 10111213", inst_s, inst_b);
        end
        tick();
        ce = 1'b0;
        n_checks++;
        if ({inst_s, inst_b} !== {exp_s(32'hC), exp_b(32'hC)}) begin
            n_fail++;
            $display("FAIL wrap_w3: got s %h b %h want %h", inst_s, inst_b, exp_b(32'hC));
        end
    endtask

    task automatic test_start_collision();
        bq_t q;
        logic [31:0] pre_b;
        logic [31:0] pre_s;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        pre_b = exp_b(32'h0);
        pre_s = exp_s(32'h0);
        ce = 1'b1; addr = 32'h0;
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h55;
        tick();
        ld_start = 1'b0; ce = 1'b0;
        n_checks++;
        if ({inst_b, inst_s, inst_valid_b, inst_valid_s} !== {pre_b, pre_s, 2'b11}) begin
            n_fail++;
            $display("FAIL fetch_at_start: got %h/%h want %h/%h", inst_b, inst_s, pre_b, pre_s);
        end
        n_checks++;
        if ({ld_ready_b, ld_ready_s, busy_b, busy_s} !== 4'b1111) begin
            n_fail++;
            $display("FAIL start_to_load: got %b want 1111",
                     {ld_ready_b, ld_ready_s, busy_b, busy_s});
        end
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_byte  = q[i];
            ld_last  = (i == 3);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        model_commit(q, 1'b1);
        n_checks++;
        if ({ld_done_b, ld_done_s} !== 2'b11) begin
            n_fail++;
            $display("FAIL collide_done: got %b want 11", {ld_done_b, ld_done_s});
        end
        ce = 1'b1; addr = 32'h0;
        tick();
        ce = 1'b0;
        n_checks++;
        if ({inst_b, inst_s} !== {32'h11223344, 32'h11223344}) begin
            n_fail++;
            $display("FAIL byte_discard: got %h/%h want 11223344", inst_b, inst_s);
        end
    endtask

    task automatic test_restart_and_ignore();
        bq_t q;
        q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'(8'h01 + i);
            tick();
        end
        ld_valid = 1'b0;
        load_image(q, 1'b1, "restart");
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
            ld_last  = (i == 2);
            tick();
            n_checks++;
            if ({ld_ready_b, ld_ready_s, ld_done_b, ld_done_s, busy_b} !== 5'b00000) begin
                n_fail++;
                $display("FAIL ignore_in_ready %0d: got %b want 00000", i,
                         {ld_ready_b, ld_ready_s, ld_done_b, ld_done_s, busy_b});
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        ce = 1'b1; addr = 32'h0;
        tick();
        addr = 32'h4;
        n_checks++;
        if ({inst_b, inst_s} !== {32'hC0C1C2C3, 32'hC0C1C2C3}) begin
            n_fail++;
            $display("FAIL restart_w0: got %h/%h want c0c1c2c3", inst_b, inst_s);
        end
        tick();
        ce = 1'b0;
        n_checks++;
        if ({inst_b, inst_s} !== {exp_b(32'h4), exp_s(32'h4)}) begin
            n_fail++;
            $display("FAIL restart_w1: got %h/%h want %h/%h", inst_b, inst_s, exp_b(32'h4),
                     exp_s(32'h4));
        end
    endtask

    task automatic test_random();
        bq_t         q;
        int          n;
        logic [31:0] a;
        logic        c;
        logic [33:0] want_b;
        logic [33:0] want_s;
        for (int it = 0; it < 8; it++) begin
            q.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            load_image(q, 1'b1, "random");
            for (int k = 0; k < 20; k++) begin
                c = ($urandom_range(0, 4) != 0);
                a = $urandom();
                a[11:2] = 10'($urandom_range(0, max_words_b - 1));
                a[1:0]  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                ce = c;
                addr = a;
                tick();
                want_b = c ? {exp_b(a), 1'b1, a[1:0] != 2'b00} : 34'h0;
                want_s = c ? {exp_s(a), 1'b1, a[1:0] != 2'b00} : 34'h0;
                n_checks++;
                if ({inst_b, inst_valid_b, addr_err_b} !== want_b) begin
                    n_fail++;
                    $display("FAIL random_b ce%b addr %h: got %h v%b e%b want %h", c, a, inst_b,
                             inst_valid_b, addr_err_b, want_b);
                end
                n_checks++;
                if ({inst_s, inst_valid_s, addr_err_s} !== want_s) begin
                    n_fail++;
                    $display("FAIL random_s ce%b addr %h: got %h v%b e%b want %h", c, a, inst_s,
                             inst_valid_s, addr_err_s, want_s);
                end
            end
            ce = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial();
        test_misaligned();
        test_load_abort();
        test_wrap();
        test_start_collision();
        test_restart_and_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
